// File: rtl/multiword_add_sequencer.sv
// Wide adder that walks one carry_lookahead_adder slice over WORDS cycles, least-significant slice first.
// Result valid WORDS edges after accept and held until result_ready; start_ready only while idle; ADDSEQ_SUB_EN adds subtract.

module carry_lookahead_adder #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o
);
    localparam int NGRP = (WIDTH + 3) / 4;
    localparam int PW   = NGRP * 4;

    logic [PW-1:0]   ap;
    logic [PW-1:0]   bp;
    logic [PW-1:0]   g;
    logic [PW-1:0]   p;
    logic [PW-1:0]   s;
    logic [PW:0]     c;
    logic [NGRP-1:0] grp_g;
    logic [NGRP-1:0] grp_p;
    logic [NGRP:0]   gc;

    // Zero padding to a whole number of 4-bit groups keeps the padded bits carry-neutral.
    assign ap = PW'(a_i);
    assign bp = PW'(b_i);
    assign g  = ap & bp;
    assign p  = ap ^ bp;

    for (genvar k = 0; k < NGRP; k++) begin : g_grp
        logic [3:0] gg;
        logic [3:0] pp;

        assign gg = g[4*k +: 4];
        assign pp = p[4*k +: 4];

        assign grp_g[k] = gg[3]
                        | (pp[3] & gg[2])
                        | (pp[3] & pp[2] & gg[1])
                        | (pp[3] & pp[2] & pp[1] & gg[0]);
        assign grp_p[k] = &pp;

        assign c[4*k]   = gc[k];
        assign c[4*k+1] = gg[0] | (pp[0] & gc[k]);
        assign c[4*k+2] = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & gc[k]);
        assign c[4*k+3] = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0])
                        | (pp[2] & pp[1] & pp[0] & gc[k]);

        assign s[4*k +: 4] = pp ^ c[4*k +: 4];
    end

    always_comb begin
        gc    = '0;
        gc[0] = cin_i;
        for (int k = 0; k < NGRP; k++) begin
            gc[k+1] = grp_g[k] | (grp_p[k] & gc[k]);
        end
    end

    assign c[PW]  = gc[NGRP];
    assign sum_o  = s[WIDTH-1:0];
    assign cout_o = c[WIDTH];
endmodule

module multiword_add_sequencer #(
    parameter int WIDTH = 32,
    parameter int WORDS = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start_valid,
    output logic                   start_ready,
    input  logic [WIDTH*WORDS-1:0] a,
    input  logic [WIDTH*WORDS-1:0] b,
    input  logic                   cin,
    input  logic                   sub,
    output logic                   result_valid,
    input  logic                   result_ready,
    output logic [WIDTH*WORDS-1:0] sum,
    output logic                   cout,
    output logic                   overflow
);
    localparam int TOTW = WIDTH * WORDS;
    localparam int IDXW = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t            state_q;
    logic [IDXW-1:0]   idx_q;
    logic              carry_q;
    logic [TOTW-1:0]   a_q;
    logic [TOTW-1:0]   b_q;
    logic [TOTW-1:0]   sum_q;
    logic              cout_q;
    logic              overflow_q;
    logic              result_valid_q;

    logic [TOTW-1:0]   b_eff_d;
    logic              seed_d;
    int                slice_base;
    logic [WIDTH-1:0]  slice_a;
    logic [WIDTH-1:0]  slice_b;
    logic [WIDTH-1:0]  slice_s;
    logic              slice_cout;
    logic              last_word;

`ifdef ADDSEQ_SUB_EN
    // Two's-complement subtract: invert B and force the carry seed to one.
    assign b_eff_d = sub ? ~b : b;
    assign seed_d  = sub ? 1'b1 : cin;
`else
    logic unused_sub;
    assign unused_sub = sub;
    assign b_eff_d    = b;
    assign seed_d     = cin;
`endif

    assign slice_base = int'(idx_q) * WIDTH;
    assign slice_a    = a_q[slice_base +: WIDTH];
    assign slice_b    = b_q[slice_base +: WIDTH];
    assign last_word  = (idx_q == IDXW'(WORDS - 1));

    carry_lookahead_adder #(
        .WIDTH (WIDTH)
    ) u_slice (
        .a_i    (slice_a),
        .b_i    (slice_b),
        .cin_i  (carry_q),
        .sum_o  (slice_s),
        .cout_o (slice_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            idx_q          <= '0;
            carry_q        <= 1'b0;
            a_q            <= '0;
            b_q            <= '0;
            sum_q          <= '0;
            cout_q         <= 1'b0;
            overflow_q     <= 1'b0;
            result_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_valid) begin
                        a_q     <= a;
                        b_q     <= b_eff_d;
                        carry_q <= seed_d;
                        idx_q   <= '0;
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    sum_q[slice_base +: WIDTH] <= slice_s;
                    carry_q <= slice_cout;
                    idx_q   <= idx_q + IDXW'(1);
                    if (last_word) begin
                        cout_q         <= slice_cout;
                        // Signed overflow: both operands disagree in sign with the result.
                        overflow_q     <= (a_q[TOTW-1] ^ slice_s[WIDTH-1])
                                        & (b_q[TOTW-1] ^ slice_s[WIDTH-1]);
                        result_valid_q <= 1'b1;
                        state_q        <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (result_ready) begin
                        result_valid_q <= 1'b0;
                        state_q        <= ST_IDLE;
                    end
                end
                default: begin
                    result_valid_q <= 1'b0;
                    state_q        <= ST_IDLE;
                end
            endcase
        end
    end

    assign start_ready  = (state_q == ST_IDLE);
    assign result_valid = result_valid_q;
    assign sum          = sum_q;
    assign cout         = cout_q;
    assign overflow     = overflow_q;
endmodule
